localbus_uart: RTL and testbench

UART peripheral attached as a slave on the local bus, alongside RAM, GPIO and VGA. It decodes its own register window from the local-bus select, address, write data and write enable. It returns read data that is forced to zero when not selected, so the bus can OR all slave outputs together. It contains a TX FIFO and serializer, an RX deserializer and FIFO, and a programmable baud divisor.

---
 rtl/localbus_uart.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_localbus_uart.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/localbus_uart.sv
// localbus_uart: local-bus UART slave with TX/RX FIFOs, serializer/deserializer and baud divisor.
// Define UART_LOOPBACK_EN to add the STATUS[8] loop bit that feeds uart_tx back into the RX path.
module localbus_uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // Full/empty come from the registered count, so a same-cycle push+pop sees start-of-cycle flags.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= AW'(wptr + 1);
            if (do_pop)  rptr <= AW'(rptr + 1);
            case ({do_push, do_pop})
                2'b10:   count <= (AW+1)'(count + 1);
                2'b01:   count <= (AW+1)'(count - 1);
                default: count <= count;
            endcase
        end
    end
endmodule

module localbus_uart #(
    parameter int XLEN        = 32,
    parameter int AWIDTH      = 14,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic [AWIDTH-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [2:0]        we,
    output logic [XLEN-1:0]   rdata,
    output logic              uart_tx,
    input  logic              uart_rx,
    output logic              irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic       wr, wr_tx, wr_rx, wr_st, wr_div;
    logic [1:0] reg_sel;
    logic       unused_bits;

    assign reg_sel     = addr[3:2];
    assign wr          = sel & (we != 3'b000);
    assign wr_tx       = wr & (reg_sel == 2'd0);
    assign wr_rx       = wr & (reg_sel == 2'd1);
    assign wr_st       = wr & (reg_sel == 2'd2);
    assign wr_div      = wr & (reg_sel == 2'd3);
    assign unused_bits = ^{addr[AWIDTH-1:4], addr[1:0], wdata[XLEN-1:16]};

    logic [15:0] baud_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      baud_div <= 16'(DEFAULT_DIV);
        else if (wr_div) baud_div <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
    end

    // ---------------- TX path ----------------
    logic        tx_full, tx_empty, tx_pop, tx_load, tx_last, tx_busy;
    logic [7:0]  tx_head;
    uart_state_t tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt, tx_div, tx_div_nxt;
    logic [2:0]  tx_bit, tx_bit_nxt;
    logic [7:0]  tx_sh, tx_sh_nxt;
    logic        tx_line, tx_line_nxt;

    localbus_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_tx), .pop(tx_pop), .din(wdata[7:0]),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    assign tx_last = (tx_cnt == tx_div - 16'd1);
    // Loading straight out of STOP keeps back-to-back frames free of an idle clock.
    assign tx_load = ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_last)) & ~tx_empty;
    assign tx_busy = (tx_state != S_IDLE) | ~tx_empty;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 16'd1;
        tx_div_nxt   = tx_div;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_pop       = 1'b0;
        case (tx_state)
            S_IDLE:  tx_cnt_nxt = '0;
            S_START: if (tx_last) begin
                tx_cnt_nxt   = '0;
                tx_bit_nxt   = '0;
                tx_state_nxt = S_DATA;
            end
            S_DATA:  if (tx_last) begin
                tx_cnt_nxt = '0;
                tx_sh_nxt  = tx_sh >> 1;
                tx_bit_nxt = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_nxt = S_STOP;
            end
            S_STOP:  if (tx_last) begin
                tx_cnt_nxt   = '0;
                tx_state_nxt = S_IDLE;
            end
            default: tx_state_nxt = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop       = 1'b1;
            tx_sh_nxt    = tx_head;
            tx_div_nxt   = baud_div;
            tx_cnt_nxt   = '0;
            tx_state_nxt = S_START;
        end
        case (tx_state_nxt)
            S_START: tx_line_nxt = 1'b0;
            S_DATA:  tx_line_nxt = tx_sh_nxt[0];
            default: tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= 16'(DEFAULT_DIV);
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_div   <= tx_div_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_sh    <= tx_sh_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    assign uart_tx = tx_line;

    // ---------------- RX path ----------------
    logic rx_in;
`ifdef UART_LOOPBACK_EN
    logic loop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     loop <= 1'b0;
        else if (wr_st) loop <= wdata[8];
    end

    assign rx_in = loop ? tx_line : uart_rx;
`else
    assign rx_in = uart_rx;
`endif

    logic [1:0]  rx_sync;
    logic        rx_prev, rx_s, rx_fall;
    logic        rx_full, rx_empty, rx_valid, rx_push, rx_mid;
    logic        set_ovr, set_ferr, rx_ovr, frame_err;
    logic [7:0]  rx_head;
    uart_state_t rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt, rx_div, rx_div_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic [7:0]  rx_sh, rx_sh_nxt;

    // Synchronizer and edge history reset high so no false start edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx_in};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;
    assign rx_mid  = (rx_cnt == rx_div - 16'd1);

    localbus_uart_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(wr_rx), .din(rx_sh),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    assign rx_valid = ~rx_empty;
    assign irq      = rx_valid;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 16'd1;
        rx_div_nxt   = rx_div;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_push      = 1'b0;
        set_ovr      = 1'b0;
        set_ferr     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_fall) begin
                    rx_div_nxt   = baud_div;
                    rx_state_nxt = S_START;
                end
            end
            // Mid-start resample rejects glitches shorter than half a bit.
            S_START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                rx_state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_mid) begin
                rx_cnt_nxt = '0;
                rx_sh_nxt  = {rx_s, rx_sh[7:1]};
                rx_bit_nxt = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
            end
            S_STOP: if (rx_mid) begin
                rx_cnt_nxt   = '0;
                rx_state_nxt = S_IDLE;
                if (!rx_s)        set_ferr = 1'b1;
                else if (rx_full) set_ovr  = 1'b1;
                else              rx_push  = 1'b1;
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= '0;
            rx_div    <= 16'(DEFAULT_DIV);
            rx_bit    <= '0;
            rx_sh     <= '0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_div   <= rx_div_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_sh    <= rx_sh_nxt;
            // Sticky set beats a same-cycle write-1-to-clear.
            if (set_ovr)                   rx_ovr <= 1'b1;
            else if (wr_st & wdata[5])     rx_ovr <= 1'b0;
            if (set_ferr)                  frame_err <= 1'b1;
            else if (wr_st & wdata[6])     frame_err <= 1'b0;
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_sel)
                2'd1: begin
                    rdata[8]   = rx_valid;
                    rdata[7:0] = rx_valid ? rx_head : 8'h00;
                end
                2'd2: begin
                    rdata[6:0] = {frame_err, rx_ovr, tx_busy, rx_full, rx_valid, tx_empty, tx_full};
`ifdef UART_LOOPBACK_EN
                    rdata[8]   = loop;
`endif
                end
                2'd3:    rdata[15:0] = baud_div;
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_localbus_uart.sv
// Self-checking bench for localbus_uart: frame-level behavioural model plus literal spot checks.
module tb_localbus_uart;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst_n = 1'b0, sel = 1'b0, uart_rx = 1'b1;
    logic [13:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  we = '0;
    logic [31:0] rdata;
    logic        uart_tx, irq;

    always #5 clk = ~clk;

    localbus_uart dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
    );

    int checks = 0, errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: TX queue plus the frame on the wire as (byte, divisor, elapsed clocks); RX queue and flags.
    logic [7:0] m_txq[$], m_rxq[$];
    bit         m_busy, m_ovr, m_ferr, m_loop, m_rx_ok, m_en;
    int         m_t, m_div, m_baud;
    logic [7:0] m_byte;

    function automatic void model_reset();
        m_txq.delete(); m_rxq.delete();
        m_busy = 0; m_ovr = 0; m_ferr = 0; m_loop = 0;
        m_t = 0; m_div = 434; m_baud = 434; m_byte = '0;
    endfunction

    function automatic logic m_line();
        int b;
        if (!m_busy) return 1'b1;
        b = m_t / m_div;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_step
        bit wr;
        int txn, rxn, baud0;
        if (!rst_n) model_reset();
        else begin
            wr = sel && (we != 0);
            txn = m_txq.size(); rxn = m_rxq.size(); baud0 = m_baud;
            if (m_busy) begin
                m_t++;
                if (m_t == 10 * m_div) m_busy = 0;
            end
            if (!m_busy && txn > 0) begin
                m_byte = m_txq.pop_front();
                m_busy = 1; m_t = 0; m_div = baud0;
            end
            if (wr) case (addr[3:2])
                2'd0: if (txn < DEPTH) m_txq.push_back(wdata[7:0]);
                2'd1: if (rxn > 0) void'(m_rxq.pop_front());
                2'd2: begin
                    if (wdata[5]) m_ovr = 0;
                    if (wdata[6]) m_ferr = 0;
`ifdef UART_LOOPBACK_EN
                    m_loop = wdata[8];
`endif
                end
                default: m_baud = (wdata[15:0] < 2) ? 2 : int'(wdata[15:0]);
            endcase
        end
    end

    function automatic void exp_rd(output logic [31:0] e, output logic [31:0] m);
        e = '0; m = '1;
        if (!sel) return;
        case (addr[3:2])
            2'd1: begin
                if (!m_rx_ok) m = '0;
                else if (m_rxq.size() > 0) e = {23'b0, 1'b1, m_rxq[0]};
            end
            2'd2: begin
                e[0] = (m_txq.size() == DEPTH);
                e[1] = (m_txq.size() == 0);
                e[2] = (m_rxq.size() > 0);
                e[3] = (m_rxq.size() == DEPTH);
                e[4] = m_busy || (m_txq.size() > 0);
                e[5] = m_ovr;
                e[6] = m_ferr;
                e[8] = m_loop;
                if (!m_rx_ok) m = ~32'h6C;
            end
            2'd3:    e = 32'(m_baud);
            default: e = '0;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        logic [31:0] e, m;
        if (rst_n && m_en) begin
            chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_line()});
            if (m_rx_ok) chk("irq", {31'b0, irq}, {31'b0, m_rxq.size() > 0});
            exp_rd(e, m);
            if (m != 0) chk("rdata", rdata & m, e & m);
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        sel = 1; addr = 14'($urandom); addr[3:2] = a[3:2]; wdata = d; we = 3'($urandom_range(1, 7));
        @(posedge clk); #1;
        sel = 0; we = 0;
    endtask

    task automatic rd(input logic s, input logic [3:0] a, input logic [31:0] exp, input string name);
        sel = s; addr = 14'($urandom); addr[3:2] = a[3:2];
        @(negedge clk);
        chk(name, rdata, exp);
        @(posedge clk); #1;
        sel = 0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        m_rx_ok = 0;
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (div) @(posedge clk);
            #1;
        end
        uart_rx = 1;
        repeat (2 * div) @(posedge clk);
        #1;
        if (!stop) m_ferr = 1;
        else if (m_rxq.size() == DEPTH) m_ovr = 1;
        else m_rxq.push_back(b);
        m_rx_ok = 1;
    endtask

    task automatic wait_tx_idle(input int budget);
        int n;
        n = 0;
        while ((m_busy || m_txq.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tx_drain_timeout", {31'b0, m_busy || m_txq.size() != 0}, 32'h0);
    endtask

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_f;
        logic [7:0] sent[DEPTH];
        int div;

        model_reset();
        m_rx_ok = 1; m_en = 0;
        // Reset state, read-gating
        repeat (2) @(posedge clk);
        #1; addr = 14'h3FFF;
        @(negedge clk);
        chk("reset_sel0_rdata", rdata, 32'h0);
        chk("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1; m_en = 1;
        rd(1, 4'h8, 32'h2, "reset_status");
        rd(1, 4'hC, 32'd434, "reset_bauddiv");
        rd(0, 4'h8, 32'h0, "sel0_status");
        rd(1, 4'h4, 32'h0, "reset_rxdata");
        rd(1, 4'h0, 32'h0, "txdata_reads_zero");

        // BAUDDIV clamp
        bus_wr(4'hC, 32'h0);     rd(1, 4'hC, 32'd2, "bauddiv_clamp0");
        bus_wr(4'hC, 32'h1);     rd(1, 4'hC, 32'd2, "bauddiv_clamp1");
        bus_wr(4'hC, 32'hF0004); rd(1, 4'hC, 32'd4, "bauddiv_4");

        // Single frame 0xA5 at divisor 4
        exp_f = {1'b1, 8'hA5, 1'b0};
        bus_wr(4'h0, 32'hA5);
        sel = 1; addr = 14'h8;
        for (int i = 0; i < 10; i++) begin
            repeat (i == 0 ? 2 : 4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("a5_bit%0d", i), {31'b0, uart_tx}, {31'b0, exp_f[i]});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a5_busy_in_stop", {31'b0, rdata[4]}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("a5_busy_cleared", rdata, 32'h2);
        @(posedge clk); #1; sel = 0;

        // Burst of 18 pushes at divisor 2: the last one lands on a full FIFO
        bus_wr(4'hC, 32'd2);
        for (int i = 0; i <= 17; i++) bus_wr(4'h0, 32'(i));
        chk("burst_model_depth", 32'(m_txq.size()), 32'd16);
        rd(1, 4'h8, 32'h11, "burst_status_full");
        wait_tx_idle(500);

        // RX frame 0x3C at divisor 8, then pop
        bus_wr(4'hC, 32'd8);
        send_rx(8'h3C, 1, 8);
        @(negedge clk);
        chk("rx_irq_set", {31'b0, irq}, 32'h1);
        @(posedge clk); #1;
        rd(1, 4'h4, 32'h13C, "rxdata_3c");
        bus_wr(4'h4, 32'hDEAD);
        rd(1, 4'h4, 32'h0, "rxdata_popped");
        @(negedge clk);
        chk("rx_irq_clear", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;

        // Start glitch shorter than half a bit is ignored
        m_rx_ok = 0;
        uart_rx = 0; repeat (2) @(posedge clk); #1;
        uart_rx = 1; repeat (30) @(posedge clk); #1;
        m_rx_ok = 1;
        rd(1, 4'h8, 32'h2, "rx_glitch_ignored");

        // Framing error and its clear
        send_rx(8'($urandom), 0, 8);
        rd(1, 4'h8, 32'h42, "status_frame_err");
        bus_wr(4'h8, 32'h40);
        rd(1, 4'h8, 32'h2, "frame_err_w1c");

        // Fill RX FIFO and overrun
        for (int i = 0; i <= DEPTH; i++) begin
            div = $urandom_range(4, 7);
            bus_wr(4'hC, 32'(div));
            if (i < DEPTH) sent[i] = 8'($urandom);
            send_rx(i < DEPTH ? sent[i] : 8'hEE, 1, div);
        end
        rd(1, 4'h8, 32'h2E, "status_overrun_full");
        bus_wr(4'h8, 32'h20);
        rd(1, 4'h8, 32'h0E, "overrun_w1c");
        for (int i = 0; i < DEPTH; i++) begin
            rd(1, 4'h4, {23'b0, 1'b1, sent[i]}, $sformatf("rx_drain%0d", i));
            bus_wr(4'h4, 32'h0);
        end
        rd(1, 4'h8, 32'h2, "rx_drained");

`ifndef UART_LOOPBACK_EN
        bus_wr(4'h8, 32'h100);
        rd(1, 4'h8, 32'h2, "loop_bit_absent");
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: bus_wr(4'h0, $urandom);
                3:       bus_wr(4'hC, 32'($urandom_range(0, 6)));
                4:       bus_wr(4'h8, $urandom & 32'hFFFF_FEFF);
                5:       bus_wr(4'h4, $urandom);
                6: begin
                    sel = 0; addr = 14'($urandom); wdata = $urandom; we = 3'($urandom_range(1, 7));
                    @(posedge clk); #1;
                    we = 0;
                end
                default: begin
                    sel = 1'($urandom); addr = 14'($urandom); wdata = $urandom; we = 0;
                    repeat ($urandom_range(1, 8)) @(posedge clk);
                    #1;
                    sel = 0;
                end
            endcase
        end
        wait_tx_idle(2000);

`ifdef UART_LOOPBACK_EN
        bus_wr(4'h8, 32'h100);
        rd(1, 4'h8, 32'h102, "loop_bit_set");
        bus_wr(4'hC, 32'd4);
        m_rx_ok = 0;
        bus_wr(4'h0, 32'h5A);
        repeat (13 * 4) @(posedge clk);
        #1;
        m_rxq.push_back(8'h5A);
        m_rx_ok = 1;
        rd(1, 4'h4, 32'h15A, "loopback_rxdata");
        bus_wr(4'h8, 32'h0);
        bus_wr(4'h4, 32'h0);
`endif

        // Asynchronous reset in the middle of a TX frame and a partial RX frame
        bus_wr(4'hC, 32'd4);
        bus_wr(4'h0, 32'h00);
        m_rx_ok = 0;
        uart_rx = 0;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("tx_midframe_low", {31'b0, uart_tx}, 32'h0);
        #2; rst_n = 0;
        #1;
        chk("async_reset_tx_high", {31'b0, uart_tx}, 32'h1);
        uart_rx = 1;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        m_rx_ok = 1;
        rd(1, 4'h8, 32'h2, "post_reset_status");
        rd(1, 4'hC, 32'd434, "post_reset_bauddiv");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
